lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 116 +++++++++++
 tb/tb_lsu.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// lsu: load/store unit bridging the memory stage to a valid/ready data bus
// Ports: req_* carries the memory-stage access in; stall, dmem_rdata, misalign and bus_err go to the pipeline;
//        bus_req_valid/bus_we/bus_addr/bus_wdata/bus_be form the bus request; bus_req_ready accepts it;
//        bus_rsp_valid/bus_rsp_data return the load word.
module lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] dmem_rdata,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_data
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [29:0] r_waddr;
  logic [1:0] r_off;
  logic [3:0] r_be;
  logic [31:0] r_wdata, r_rdata;
  logic [2:0] r_f3;
  logic r_we;
  logic [1:0] w_sz;
  logic w_mis, w_start, w_rsp, w_tmo;
  logic [3:0] w_be;
  logic [31:0] w_wdata, w_ld;
  logic [7:0] w_byte;
  logic [15:0] w_half;
  // w_sz: 00 byte, 01 half, else word; store encodings with funct3[2] set are unsupported and fall back to word
  assign w_sz = (req_we && req_funct3[2]) ? 2'b10 : req_funct3[1:0];
  assign w_mis = w_sz == 2'b01 ? req_addr[0] : w_sz != 2'b00 && req_addr[1:0] != 2'b00;
  assign w_be = w_sz == 2'b00 ? 4'b0001 << req_addr[1:0] :
                w_sz == 2'b01 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_wdata = w_sz == 2'b00 ? {4{req_wdata[7:0]}} :
                   w_sz == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
  assign w_byte = bus_rsp_data[{r_off, 3'b000} +: 8];
  assign w_half = bus_rsp_data[{r_off[1], 4'b0000} +: 16];
  // funct3[2] selects zero extension for LBU/LHU
  assign w_ld = r_f3[1:0] == 2'b00 ? {{24{~r_f3[2] & w_byte[7]}}, w_byte} :
                r_f3[1:0] == 2'b01 ? {{16{~r_f3[2] & w_half[15]}}, w_half} : bus_rsp_data;
  assign dmem_rdata = r_rdata;
  assign bus_we = r_we;
  assign bus_addr = {r_waddr, 2'b00};
  assign bus_wdata = r_wdata;
  assign bus_be = r_be;
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    w_start = 1'b0;
    w_rsp = 1'b0;
    w_tmo = 1'b0;
    misalign = 1'b0;
    bus_err = 1'b0;
    bus_req_valid = 1'b0;
    stall = req_valid && !w_mis && r_state != DONE;
    case (r_state)
      IDLE: begin
        misalign = req_valid && w_mis;
        w_start = req_valid && !w_mis;
        w_next = w_start ? REQ : IDLE;
      end
      REQ: begin
        bus_req_valid = 1'b1;
        // a load response arriving together with acceptance is taken immediately
        w_rsp = bus_req_ready && !r_we && bus_rsp_valid;
        w_next = !bus_req_ready ? REQ : (r_we || bus_rsp_valid) ? DONE : WAIT;
      end
      WAIT: begin
        w_rsp = bus_rsp_valid;
        w_tmo = !bus_rsp_valid && r_cnt == CW'(TIMEOUT_CYCLES - 1);
        bus_err = w_tmo;
        w_next = (w_rsp || w_tmo) ? DONE : WAIT;
      end
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_waddr <= '0;
      r_off <= '0;
      r_be <= '0;
      r_wdata <= '0;
      r_f3 <= '0;
      r_we <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_start) begin
        r_waddr <= req_addr[31:2];
        r_off <= req_addr[1:0];
        r_be <= w_be;
        r_wdata <= w_wdata;
        r_f3 <= req_funct3;
        r_we <= req_we;
      end
      r_cnt <= r_state == WAIT ? r_cnt + 1'b1 : '0;
      r_rdata <= w_rsp ? w_ld : w_tmo ? '0 : r_rdata;
    end
  end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed bench for lsu against a transaction-level model of the access timeline
module tb_lsu;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst, req_valid, req_we;
  logic [2:0] req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic stall, misalign, bus_err, bus_req_valid, bus_req_ready, bus_we, bus_rsp_valid;
  logic [31:0] dmem_rdata, bus_addr, bus_wdata, bus_rsp_data;
  logic [3:0] bus_be;
  int checks = 0;
  int failures = 0;
  int n_stall = 0;
  logic chk = 1'b0;
  logic m_stall, m_busv, m_mis, m_err, m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0] m_be;
  logic [31:0] last_addr, last_wdata;
  logic [3:0] last_be;
  logic last_we;

  lsu #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall), .dmem_rdata(dmem_rdata),
    .misalign(misalign), .bus_err(bus_err), .bus_req_valid(bus_req_valid),
    .bus_req_ready(bus_req_ready), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic we, input logic [2:0] f3);
    if (f3 == 3'b000 || (!we && f3 == 3'b100)) return 1;
    if (f3 == 3'b001 || (!we && f3 == 3'b101)) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] be_model(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int n = nbytes(we, f3);
    int off = int'(a[1:0]);
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] wd_model(input logic we, input logic [2:0] f3, input logic [31:0] d);
    int n = nbytes(we, f3);
    if (n == 1) return {24'b0, d[7:0]} * 32'h0101_0101;
    if (n == 2) return {16'b0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    int n = nbytes(1'b0, f3);
    int off = int'(a[1:0]);
    logic [31:0] mask = n == 4 ? 32'hFFFF_FFFF : (32'd1 << (8 * n)) - 32'd1;
    logic [31:0] v = (w >> (8 * off)) & mask;
    if (n < 4 && (f3 == 3'b000 || f3 == 3'b001) && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  always @(negedge clk) if (chk) begin
    cmp("stall", 32'(stall), 32'(m_stall));
    cmp("bus_req_valid", 32'(bus_req_valid), 32'(m_busv));
    cmp("misalign", 32'(misalign), 32'(m_mis));
    cmp("bus_err", 32'(bus_err), 32'(m_err));
    cmp("dmem_rdata", dmem_rdata, m_rdata);
    if (m_busv) begin
      cmp("bus_addr", bus_addr, m_addr);
      cmp("bus_we", 32'(bus_we), 32'(m_we));
      if (m_we) begin
        cmp("bus_be", 32'(bus_be), 32'(m_be));
        cmp("bus_wdata", bus_wdata, m_wdata);
      end
    end
    if (stall) n_stall++;
    if (bus_req_valid && bus_req_ready) begin
      last_addr = bus_addr;
      last_wdata = bus_wdata;
      last_be = bus_be;
      last_we = bus_we;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tick();
    req_valid = 1'b0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    m_stall = 1'b0;
    m_busv = 1'b0;
    m_mis = 1'b0;
    m_err = 1'b0;
  endtask

  // sdly: >=0 response that many cycles into WAIT, -1 together with acceptance, -2 never
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                        input int rdly, input int sdly, input logic [31:0] rsp, input logic noise);
    int n = nbytes(we, f3);
    logic mis = (a % n) != 0;
    int t_acc = 1 + rdly;
    int t_rsp = (we || sdly == -2) ? -1 : sdly == -1 ? t_acc : t_acc + 1 + sdly;
    int t_err = (!we && sdly == -2) ? t_acc + TO : -1;
    int t_done = mis ? 0 : we ? t_acc + 1 : t_rsp >= 0 ? t_rsp + 1 : t_err + 1;
    logic [31:0] nxt = mis || we ? m_rdata : t_err >= 0 ? 32'h0 : ld_model(f3, a, rsp);
    m_addr = a & ~32'd3;
    m_we = we;
    m_be = be_model(we, f3, a);
    m_wdata = wd_model(we, f3, wd);
    for (int k = 0; k <= t_done; k++) begin
      tick();
      req_valid = 1'b1;
      req_we = we;
      req_funct3 = f3;
      req_addr = a;
      req_wdata = wd;
      bus_req_ready = !mis && k == t_acc;
      bus_rsp_valid = k == t_rsp || (noise && (k < t_acc || k == t_done));
      bus_rsp_data = k == t_rsp ? rsp : 32'hDEAD_BEEF;
      m_stall = !mis && k < t_done;
      m_busv = !mis && k >= 1 && k <= t_acc;
      m_mis = mis && k == 0;
      m_err = k == t_err;
      if (k == t_done) m_rdata = nxt;
    end
    idle();
  endtask

  initial begin
    int s0;
    rst = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_funct3 = 3'b000;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    bus_req_ready = 1'b0;
    bus_rsp_valid = 1'b0;
    bus_rsp_data = 32'h0;
    m_stall = 1'b0;
    m_busv = 1'b0;
    m_mis = 1'b0;
    m_err = 1'b0;
    m_we = 1'b0;
    m_addr = 32'h0;
    m_wdata = 32'h0;
    m_be = 4'h0;
    m_rdata = 32'h0;
    tick();
    chk = 1'b1;
    tick();
    rst = 1'b0;
    s0 = n_stall;
    access(1'b0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80FF_0000, 1'b0);
    cmp("lb_stall_cycles", 32'(n_stall - s0), 32'd3);
    cmp("lb_rdata", dmem_rdata, 32'hFFFF_FF80);
    cmp("lb_bus_addr", last_addr, 32'h0000_0100);
    s0 = n_stall;
    access(1'b1, 3'b001, 32'h202, 32'h0000_BEEF, 0, 0, 32'h0, 1'b1);
    cmp("sh_stall_cycles", 32'(n_stall - s0), 32'd2);
    cmp("sh_be", 32'(last_be), 32'hC);
    cmp("sh_wdata", last_wdata, 32'hBEEF_BEEF);
    cmp("sh_we", 32'(last_we), 32'd1);
    cmp("sh_rdata_kept", dmem_rdata, 32'hFFFF_FF80);
    access(1'b0, 3'b010, 32'h6, 32'h0, 0, 0, 32'h0, 1'b0);
    access(1'b0, 3'b101, 32'h0, 32'h0, 5, 0, 32'h0000_8001, 1'b1);
    cmp("lhu_rdata", dmem_rdata, 32'h0000_8001);
    access(1'b0, 3'b010, 32'h10, 32'h0, 0, -2, 32'h0, 1'b0);
    cmp("timeout_rdata", dmem_rdata, 32'h0);
    access(1'b0, 3'b001, 32'h2, 32'h0, 1, -1, 32'h8001_1234, 1'b0);
    cmp("lh_same_cycle", dmem_rdata, 32'hFFFF_8001);
    access(1'b0, 3'b100, 32'h101, 32'h0, 0, 2, 32'h0000_9A00, 1'b1);
    cmp("lbu_rdata", dmem_rdata, 32'h0000_009A);
    access(1'b1, 3'b000, 32'h3, 32'h1234_5678, 1, 0, 32'h0, 1'b0);
    cmp("sb_be", 32'(last_be), 32'h8);
    cmp("sb_wdata", last_wdata, 32'h7878_7878);
    access(1'b1, 3'b010, 32'h10, 32'hCAFE_F00D, 2, 0, 32'h0, 1'b1);
    access(1'b0, 3'b001, 32'h5, 32'h0, 0, 0, 32'h0, 1'b0);
    access(1'b1, 3'b001, 32'h7, 32'h1111_2222, 0, 0, 32'h0, 1'b0);
    access(1'b0, 3'b011, 32'h8, 32'h0, 0, 1, 32'h89AB_CDEF, 1'b0);
    cmp("f3_011_word", dmem_rdata, 32'h89AB_CDEF);
    access(1'b0, 3'b110, 32'h2, 32'h0, 0, 0, 32'h0, 1'b0);
    access(1'b1, 3'b100, 32'h20, 32'hA5A5_0F0F, 0, 0, 32'h0, 1'b0);
    cmp("sb100_be", 32'(last_be), 32'hF);
    access(1'b0, 3'b000, 32'h0, 32'h0, 0, 0, 32'h0000_007F, 1'b0);
    cmp("lb_pos", dmem_rdata, 32'h0000_007F);
    tick();
    req_valid = 1'b1;
    req_we = 1'b0;
    req_funct3 = 3'b010;
    req_addr = 32'h40;
    m_stall = 1'b1;
    m_addr = 32'h40;
    m_we = 1'b0;
    tick();
    bus_req_ready = 1'b1;
    m_busv = 1'b1;
    tick();
    bus_req_ready = 1'b0;
    rst = 1'b1;
    m_busv = 1'b0;
    tick();
    rst = 1'b0;
    req_valid = 1'b0;
    bus_rsp_valid = 1'b1;
    bus_rsp_data = 32'h1234_5678;
    m_stall = 1'b0;
    m_rdata = 32'h0;
    idle();
    cmp("rst_wait_rdata", dmem_rdata, 32'h0);
    access(1'b0, 3'b010, 32'h44, 32'h0, 0, 0, 32'h0BAD_F00D, 1'b0);
    cmp("after_rst_lw", dmem_rdata, 32'h0BAD_F00D);
    tick();
    chk = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
